joypad_target: RTL

JOYPAD_TARGET -- requirements
Module: joypad_target

---
 rtl/joypad_bus_pkg.sv | 27 ++
 rtl/bus_sync.sv | 33 +++
 rtl/joypad_target.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/joypad_bus_pkg.sv
// Shared definitions for the joypad serial bus: FSM encoding, default address,
// pad geometry and counter widths. Used by both target and initiator sides.
package joypad_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  localparam logic [6:0] DEFAULT_ADDR = 7'h52;
  localparam int         PAD_BYTES    = 4;
  localparam int         BIT_CNT_W    = 4;
  localparam int         BYTE_IDX_W   = $clog2(PAD_BYTES);

  localparam logic [BIT_CNT_W-1:0] BYTE_BITS = BIT_CNT_W'(8);

  // Byte n of a pad snapshot lives in bits [8n+7:8n].
  function automatic logic [7:0] pad_byte(input logic [8*PAD_BYTES-1:0] snap,
                                          input logic [BYTE_IDX_W-1:0]  idx);
    return snap[8*idx +: 8];
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Brings one asynchronous bus line into the clk domain and reports its
// synchronized level together with single-cycle rise/fall strobes.
module bus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              hist;

  // NOTE: flops reset to 1 (the idle bus level) so no false edge is seen
  // when reset is released; reset is asynchronous so the bus is let go at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '1;
      hist <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      hist <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~hist;
  assign fall  = ~level & hist;

endmodule

// File: rtl/joypad_target.sv
// Read-only bus target returning a snapshot of four pad bytes, taken at the
// address ACK and sent byte 0 first, MSB first, index wrapping modulo 4.
module joypad_target
  import joypad_bus_pkg::*;
#(
  parameter logic [6:0] ADDR        = DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  input  logic [31:0] buttons,
  output logic        busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  bus_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (scl_in),
    .level (scl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  bus_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (sda_in),
    .level (sda),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  logic start_cond, stop_cond;
  assign start_cond = scl & sda_fall;
  assign stop_cond  = scl & sda_rise;

  state_t                   state, state_d;
  logic [BIT_CNT_W-1:0]     bit_cnt, bit_cnt_d;
  logic [7:0]               shift, shift_d;
  logic [7:0]               tx, tx_d;
  logic [8*PAD_BYTES-1:0]   snapshot, snapshot_d;
  logic [BYTE_IDX_W-1:0]    byte_idx, byte_idx_d;
  logic                     ack_seen, ack_seen_d;
  logic                     sda_q, sda_d;
  logic                     busy_q, busy_d;
  logic [7:0]               cur_byte;

  assign cur_byte = pad_byte(snapshot, byte_idx);

  // NOTE: every next-state variable gets its hold value first, so no path
  // through the case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    shift_d    = shift;
    tx_d       = tx;
    snapshot_d = snapshot;
    byte_idx_d = byte_idx;
    ack_seen_d = ack_seen;
    sda_d      = sda_q;
    busy_d     = busy_q;

    // Bus conditions outrank any data sampling in the same cycle.
    if (stop_cond) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (start_cond) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_d     = 1'b1;
      busy_d    = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR: begin
          if (scl_rise && bit_cnt < BYTE_BITS) begin
            shift_d   = {shift[6:0], sda};
            bit_cnt_d = bit_cnt + 1'b1;
          end else if (scl_fall && bit_cnt == BYTE_BITS) begin
            if (shift[7:1] == ADDR && shift[0]) begin
              sda_d      = 1'b0;
              busy_d     = 1'b1;
              snapshot_d = buttons;
              byte_idx_d = '0;
              state_d    = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK, ST_TX_ACK: begin
          if (state == ST_TX_ACK && scl_rise) begin
            if (!sda) begin
              ack_seen_d = 1'b1;
              byte_idx_d = byte_idx + 1'b1;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && (state == ST_ADDR_ACK || ack_seen)) begin
            sda_d     = cur_byte[7];
            tx_d      = {cur_byte[6:0], 1'b1};
            bit_cnt_d = BIT_CNT_W'(1);
            state_d   = ST_TX;
          end
        end
        ST_TX: begin
          if (scl_fall) begin
            if (bit_cnt == BYTE_BITS) begin
              sda_d      = 1'b1;
              ack_seen_d = 1'b0;
              state_d    = ST_TX_ACK;
            end else begin
              sda_d     = tx[7];
              tx_d      = {tx[6:0], 1'b1};
              bit_cnt_d = bit_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= '1;
      snapshot <= '0;
      byte_idx <= '0;
      ack_seen <= 1'b0;
      sda_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      shift    <= shift_d;
      tx       <= tx_d;
      snapshot <= snapshot_d;
      byte_idx <= byte_idx_d;
      ack_seen <= ack_seen_d;
      sda_q    <= sda_d;
      busy_q   <= busy_d;
    end
  end

  assign sda_out = sda_q;
  assign busy    = busy_q;

endmodule
